// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with bypass, busy scoreboard and bulk clear
// Decode-stage integer register file: x0 hard-wired to zero, reads combinational, writes on the rising edge.

module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int NUM_RD    = 2,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   issue_en,
    input  logic [AW-1:0]          issue_rd,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done
);

    localparam logic [AW:0]   REG_LIM = (AW+1)'(REG_COUNT);
    localparam logic [AW-1:0] LAST    = AW'(REG_COUNT - 1);
    localparam logic          BYP_EN  = (BYPASS != 0);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [AW-1:0]         idx;
    logic                  clr_last;
    logic [XLEN-1:0]       regs [REG_COUNT];
    logic [REG_COUNT-1:0]  busy;
    logic                  wr_ok;
    logic                  iss_ok;

    // Non-power-of-two files leave a hole at the top of the address space.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < REG_LIM);
    endfunction

    assign wr_ok  = (state == IDLE) && wr_en && (wr_addr != '0) && in_range(wr_addr);
    assign iss_ok = (state == IDLE) && issue_en && (issue_rd != '0) && in_range(issue_rd);

    always_comb begin
        state_nx = state;
        clr_last = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                if (idx == LAST) begin
                    state_nx = IDLE;
                    clr_last = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_done <= clr_last;
        end
    end

    assign clr_busy = (state == CLEAR);

    // The issue update follows the write so a same-cycle new producer leaves the register busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
            idx  <= '0;
        end else if (state == CLEAR) begin
            regs[idx] <= '0;
            busy[idx] <= 1'b0;
            idx       <= idx + 1'b1;
        end else begin
            if (clr_req) begin
                idx <= AW'(1);
            end
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (iss_ok) begin
                busy[issue_rd] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        logic          valid;
        logic          hit;

        assign ra    = rd_addr[k*AW +: AW];
        assign valid = (ra != '0) && in_range(ra);
        assign hit   = BYP_EN && wr_ok && (wr_addr == ra);

        assign rd_data[k*XLEN +: XLEN] = !valid ? '0 : (hit ? wr_data : regs[ra]);
        assign rd_busy[k]              = valid && busy[ra];
    end

endmodule
